// File: rtl/modulator_pwm_gen.sv
// rtl/modulator_pwm_gen.sv - sample-FIFO driven PWM modulator with nsync/bclk/symb_clk framing strobes
// Optional complementary output pwm_n with dead-time: define COMPL_OUT_EN.
module modulator_pwm_gen #(
  parameter int DATA_WIDTH       = 8,
  parameter int CLKS_PER_STEP    = 10,
  parameter int STEPS_PER_SAMPLE = 255,
  parameter int DEAD_CLKS        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  center_mode,
  input  logic                  underrun_hold,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic                  empty,
  output logic                  read,
  output logic                  pwm,
`ifdef COMPL_OUT_EN
  output logic                  pwm_n,
`endif
  output logic                  nsync,
  output logic                  bclk,
  output logic                  symb_clk,
  output logic                  underrun
);
  localparam int S  = STEPS_PER_SAMPLE;
  localparam int CW = $clog2(S + 1);
  localparam int PW = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
  localparam int MW = (DATA_WIDTH > CW) ? DATA_WIDTH : CW;
  localparam logic [CW-1:0] S_C    = CW'(S);
  localparam logic [CW-1:0] LAST_S = CW'(S - 1);
  localparam logic [CW-1:0] HALF_S = CW'(S / 2);
  localparam logic [PW-1:0] LAST_P = PW'(CLKS_PER_STEP - 1);

  typedef enum logic [1:0] {IDLE, FETCH, RUN} state_t;

  state_t                state, nxt_state;
  logic [PW-1:0]         presc, nxt_presc, adv_presc;
  logic [CW-1:0]         step, nxt_step, adv_step;
  logic [DATA_WIDTH-1:0] duty;
  logic                  mode_c, warm;
  logic                  tick, counting, period_end, fetch_go, nxt_counting, period_start;
  logic [MW-1:0]         duty_x;
  logic [CW-1:0]         dc, lo;
  logic                  raw, pwm_nxt;

  // warm marks a FETCH that overlaps the first clk of a running period; the
  // FETCH after IDLE holds the counters so RUN starts cleanly at step 0.
  always_comb begin
    tick       = (presc == LAST_P);
    adv_presc  = tick ? '0 : presc + 1'b1;
    adv_step   = !tick ? step : ((step == LAST_S) ? '0 : step + 1'b1);
    counting   = (state == RUN) || ((state == FETCH) && warm);
    period_end = (state == RUN) && tick && (step == LAST_S);
    nxt_state  = state;
    nxt_presc  = '0;
    nxt_step   = '0;
    fetch_go   = 1'b0;
    if (!enable) begin
      nxt_state = IDLE;
    end else begin
      if (counting) begin
        nxt_presc = adv_presc;
        nxt_step  = adv_step;
      end
      case (state)
        IDLE: begin
          nxt_state = FETCH;
          fetch_go  = 1'b1;
        end
        FETCH: nxt_state = RUN;
        RUN: begin
          if (period_end) begin
            nxt_state = FETCH;
            fetch_go  = 1'b1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
    nxt_counting = enable && ((nxt_state == RUN) || period_end);
    period_start = enable && (((state == FETCH) && !warm) || period_end);
    duty_x  = MW'(duty);
    dc      = (duty_x > MW'(S)) ? S_C : CW'(duty_x);
    lo      = (S_C - dc) >> 1;
    raw     = mode_c ? ((step >= lo) && (step < lo + dc)) : (step < dc);
    pwm_nxt = enable && counting && raw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      presc    <= '0;
      step     <= '0;
      duty     <= '0;
      mode_c   <= 1'b0;
      warm     <= 1'b0;
      read     <= 1'b0;
      underrun <= 1'b0;
      nsync    <= 1'b1;
      bclk     <= 1'b0;
      symb_clk <= 1'b0;
    end else begin
      state    <= nxt_state;
      presc    <= nxt_presc;
      step     <= nxt_step;
      read     <= 1'b0;
      underrun <= 1'b0;
      if (fetch_go) begin
        read     <= !empty;
        underrun <= empty;
        if (!empty)
          duty <= sample;
        else if (!underrun_hold)
          duty <= '0;
        mode_c <= center_mode;
        warm   <= (state == RUN);
      end
      nsync    <= !period_start;
      bclk     <= enable && (bclk ^ (counting && tick));
      symb_clk <= nxt_counting && (nxt_step < HALF_S);
    end
  end

`ifdef COMPL_OUT_EN
  localparam int DW = $clog2(DEAD_CLKS + 2);
  localparam logic [DW-1:0] DEAD_SAT = DW'(DEAD_CLKS + 1);

  logic          raw_q;
  logic [DW-1:0] run_len, nxt_len;

  // run_len counts clks the raw level has held, including this one; an output
  // may only assert once the level has been stable for DEAD_CLKS earlier clks.
  always_comb begin
    nxt_len = (pwm_nxt != raw_q) ? DW'(1) :
              ((run_len == DEAD_SAT) ? run_len : run_len + 1'b1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_q   <= 1'b0;
      run_len <= '0;
      pwm     <= 1'b0;
      pwm_n   <= 1'b0;
    end else begin
      raw_q   <= pwm_nxt;
      run_len <= (nxt_state == IDLE) ? '0 : nxt_len;
      pwm     <= pwm_nxt && (nxt_len == DEAD_SAT);
      pwm_n   <= (nxt_state != IDLE) && !pwm_nxt && (nxt_len == DEAD_SAT);
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pwm <= 1'b0;
    else
      pwm <= pwm_nxt;
  end
`endif

endmodule

// File: tb/tb_modulator_pwm_gen.sv
// tb/tb_modulator_pwm_gen.sv - directed self-checking bench for modulator_pwm_gen
module tb_modulator_pwm_gen;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic         center_mode = 1'b0;
  logic         underrun_hold = 1'b1;
  logic [W-1:0] sample;
  logic         empty;
  logic         read, pwm, nsync, bclk, symb_clk, underrun;
`ifdef COMPL_OUT_EN
  logic         pwm_n;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int w_hi, w_rd, w_ns, w_sy, w_ur, w_bt, w_first, w_hn, w_both;
  logic [W-1:0] fifo_q[$];

  always #5 clk = ~clk;

  modulator_pwm_gen #(
    .DATA_WIDTH(W), .CLKS_PER_STEP(2), .STEPS_PER_SAMPLE(15), .DEAD_CLKS(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .center_mode(center_mode),
    .underrun_hold(underrun_hold), .sample(sample), .empty(empty),
    .read(read), .pwm(pwm),
`ifdef COMPL_OUT_EN
    .pwm_n(pwm_n),
`endif
    .nsync(nsync), .bclk(bclk), .symb_clk(symb_clk), .underrun(underrun)
  );

  function automatic void fifo_update();
    empty  = (fifo_q.size() == 0);
    sample = empty ? 4'hA : fifo_q[0];
  endfunction

  // Show-ahead FIFO: the head word is consumed while read is high.
  always @(negedge clk) begin
    if (rst && read && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      fifo_update();
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int v);
    fifo_q.push_back(W'(v));
    fifo_update();
  endtask

  // One 30-clk window aligned so that its last clk is the next period's nsync clk.
  task automatic run_window();
    logic prev_b;
    w_hi = 0; w_rd = 0; w_ns = 0; w_sy = 0; w_ur = 0; w_bt = 0; w_hn = 0; w_both = 0;
    w_first = -1;
    prev_b = bclk;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pwm) begin
        w_hi++;
        if (w_first < 0) w_first = i;
      end
      if (read) w_rd++;
      if (!nsync) w_ns++;
      if (symb_clk) w_sy++;
      if (underrun) w_ur++;
      if (bclk != prev_b) w_bt++;
      prev_b = bclk;
`ifdef COMPL_OUT_EN
      if (pwm_n) w_hn++;
      if (pwm && pwm_n) w_both++;
`endif
    end
  endtask

  task automatic start_run(input string tag);
    @(negedge clk);
    check_eq({tag, "_first_read"}, read, 1);
    check_eq({tag, "_first_nsync_hi"}, nsync, 1);
    @(negedge clk);
    check_eq({tag, "_nsync_lo"}, nsync, 0);
    check_eq({tag, "_read_once"}, read, 0);
  endtask

  task automatic stop_run();
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int t2_in[4];
    int t2_hi[4];
    t2_in = '{3, 5, 0, 15};
    t2_hi = '{6, 10, 0, 30};
    enable = 1'b1;
    sample = 4'hA;
    empty  = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_pwm", pwm, 0);
    check_eq("rst_read", read, 0);
    check_eq("rst_nsync", nsync, 1);
    check_eq("rst_bclk", bclk, 0);
    check_eq("rst_symb", symb_clk, 0);
    check_eq("rst_underrun", underrun, 0);

`ifdef COMPL_OUT_EN
    push(5); push(5); push(5);
    rst = 1'b1;
    start_run("dt");
    run_window();
    run_window();
    check_eq("dt_pwm_hi", w_hi, 8);
    check_eq("dt_pwm_n_hi", w_hn, 18);
    check_eq("dt_overlap", w_both, 0);
    stop_run();
    check_eq("dt_idle_pwm_n", pwm_n, 0);
`else
    foreach (t2_in[i]) push(t2_in[i]);
    rst = 1'b1;
    start_run("t2");
    for (int k = 0; k < 4; k++) begin
      run_window();
      check_eq($sformatf("t2_pwm_hi%0d", k), w_hi, t2_hi[k]);
      check_eq($sformatf("t2_reads%0d", k), w_rd, (k < 3) ? 1 : 0);
      check_eq($sformatf("t2_nsync%0d", k), w_ns, 1);
      if (k == 0) begin
        check_eq("t2_symb_hi", w_sy, 14);
        check_eq("t2_bclk_toggles", w_bt, 15);
      end
    end
    check_eq("t2_underrun", w_ur, 1);
    stop_run();
    check_eq("t2_idle_pwm", pwm, 0);
    check_eq("t2_idle_nsync", nsync, 1);

    push(5); push(5);
    center_mode = 1'b1;
    enable = 1'b1;
    start_run("t3");
    center_mode = 1'b0;
    run_window();
    check_eq("t3_ctr_first", w_first, 10);
    check_eq("t3_ctr_hi", w_hi, 10);
    run_window();
    check_eq("t3_edge_first", w_first, 0);
    check_eq("t3_edge_hi", w_hi, 10);
    stop_run();

    underrun_hold = 1'b1;
    push(7);
    enable = 1'b1;
    start_run("t4");
    run_window();
    check_eq("t4_w1_hi", w_hi, 14);
    check_eq("t4_w1_read", w_rd, 0);
    check_eq("t4_w1_underrun", w_ur, 1);
    underrun_hold = 1'b0;
    run_window();
    check_eq("t4_hold_hi", w_hi, 14);
    check_eq("t4_hold_read", w_rd, 0);
    check_eq("t4_hold_underrun", w_ur, 1);
    run_window();
    check_eq("t4_zero_hi", w_hi, 0);
    check_eq("t4_zero_underrun", w_ur, 1);
    stop_run();

    underrun_hold = 1'b1;
    push(9); push(9);
    enable = 1'b1;
    start_run("t5");
    repeat (12) @(negedge clk);
    check_eq("t5_pwm_before_off", pwm, 1);
    enable = 1'b0;
    @(negedge clk);
    check_eq("t5_pwm_off", pwm, 0);
    w_rd = 0;
    repeat (40) begin
      @(negedge clk);
      if (read) w_rd++;
    end
    check_eq("t5_idle_reads", w_rd, 0);
    check_eq("t5_idle_symb", symb_clk, 0);
    enable = 1'b1;
    start_run("t5_re");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/modulator_pwm_gen.md
Name: modulator_pwm_gen

Overview:
Parametrised successor to the single-channel AM PWM modulator. Pulls samples from a show-ahead FIFO and converts each one to a PWM duty over one sample period, with edge-aligned or centre-aligned mode, selectable underrun policy and an underrun indicator. It also emits the framing strobes (nsync, bclk, symb_clk) used downstream. It sits between the sample FIFO and the RF output pin driver.

Parameters:
DATA_WIDTH, 8, sample width in bits (W).
CLKS_PER_STEP, 10, clk cycles per PWM step (>=1).
STEPS_PER_SAMPLE, 255, PWM steps per sample period (S, >=2).
DEAD_CLKS, 2, dead-time in clocks; used only with COMPL_OUT_EN.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
enable  in  1  run request
center_mode  in  1  0 = edge-aligned, 1 = centre-aligned
underrun_hold  in  1  1 = repeat last duty on underrun, 0 = force duty 0
sample  in  W  FIFO head word, valid whenever empty=0
empty  in  1  FIFO empty
read  out  1  one-clk pop strobe
pwm  out  1  modulated output
nsync  out  1  active-low pulse, 1 clk, at sample period start
bclk  out  1  toggles every step tick
symb_clk  out  1  high during first half of sample period
underrun  out  1  one-clk pulse when a fetch finds empty=1

Behaviour:
- Reset (rst=0, async): pwm=0, read=0, nsync=1, bclk=0, symb_clk=0, underrun=0. State IDLE; counters, duty and latched mode cleared to 0.
- Counters: presc counts 0..CLKS_PER_STEP-1. Step tick when presc wraps. step counts 0..S-1 on ticks. Period = CLKS_PER_STEP*S clks.
- States:
  - IDLE: counters held at 0, outputs at reset values.
  - FETCH: single cycle.
  - RUN.
- Transitions:
  - IDLE -> FETCH when enable=1.
  - FETCH -> RUN, always.
  - RUN -> FETCH on the last clk of a period (presc=max, step=S-1).
  - Any state -> IDLE on the clk after enable=0. enable low beats a simultaneous fetch: no read is issued.
- FETCH:
  - If empty=0: read=1 this cycle, duty <= sample.
  - If empty=1: read=0, underrun=1 this cycle; duty <= previous duty if underrun_hold=1, else 0.
  - center_mode is latched here. Mode changes take effect only at the next period boundary.
- Duty width rule:
  - duty is W bits, zero-extended to clog2(S+1) bits for comparison.
  - dc = min(duty, S).
- pwm (registered; reflects the counter state of the previous clk):
  - Edge mode: high when step < dc.
  - Centre mode: lo = (S-dc)>>1; high when lo <= step < lo+dc.
  - dc=0 gives constant low; dc=S gives constant high with no glitch across period boundaries.
- nsync = 0 for exactly the first clk of each RUN period (step=0, presc=0).
- bclk toggles on each step tick in RUN.
- symb_clk = 1 while step < S/2 (integer division) in RUN.
- read is never asserted when empty=1, and never more than once per period.
- Re-enable after IDLE restarts from step 0 with a fresh FETCH. The first read occurs 1 clk after enable rises.

Optional Feature:
COMPL_OUT_EN:
- Defined:
  - Adds output pwm_n (1 bit) and a dead-time generator.
  - pwm rises only after the raw PWM has been high for DEAD_CLKS consecutive clks.
  - pwm_n rises only after the raw PWM has been low for DEAD_CLKS consecutive clks.
  - pwm and pwm_n are never simultaneously high.
  - Pulses shorter than DEAD_CLKS are suppressed.
  - Reset/IDLE: pwm=0, pwm_n=0.
- Not defined: no pwm_n port; pwm is the raw registered PWM described above.

Test Plan:
Bench parameters: W=4, CLKS_PER_STEP=2, S=15, giving a 30-clk period.
1. Reset: hold rst=0 with enable=1 and sample=4'hA -> pwm=0, read=0, nsync=1, bclk=0, symb_clk=0, underrun=0. No change until rst=1.
2. Edge mode, FIFO supplies 3,5,0,15 -> pwm high 6,10,0,30 clks in successive periods. Exactly one read per 30 clks; nsync low 1 clk per period; bclk period 4 clks; symb_clk high 14 clks per period.
3. Centre mode, sample 5 -> lo=5; pwm high on period clks 10..19 (offset 1 for output register). Mode toggled mid-period takes effect at the next period only.
4. Sample 7, then empty=1 with underrun_hold=1 -> no read, one underrun pulse per period, pwm high 14 clks each period. With underrun_hold=0 -> pwm constant 0.
5. Deassert enable at step 6 -> pwm=0 next clk, no further read. Reassert -> read 1 clk later, nsync low 1 clk after that.
6. With COMPL_OUT_EN, DEAD_CLKS=2, sample 5 edge mode -> pwm high 8 clks, pwm_n low-gap 2 clks at each edge, never both high.
